line_mem_responder: RTL and testbench
=====================================

LINE_MEM_RESPONDER -- requirements
Module: line_mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4: cycles from request acceptance to pmem_resp; legal range 1..15.
REQ-002 SHALL have parameter IDX_W, default 4: line-index width; storage is 2**IDX_W lines.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port pmem_read, input, 1: line read request, held high until pmem_resp.
REQ-006 SHALL have port pmem_write, input, 1: line write request, held high until pmem_resp.
REQ-007 SHALL have port pmem_address, input, lc3b_word (16): byte address; bits [3:0] ignored.
REQ-008 SHALL have port pmem_wdata, input, lc3b_line (128): write line.
REQ-009 SHALL have port pmem_resp, output, 1: single-cycle completion pulse.
REQ-010 SHALL have port pmem_rdata, output, lc3b_line (128): read line.
REQ-011 SHALL have port proto_err, output, 1: sticky protocol-violation flag.

Function
REQ-012 SHALL implement FSM IDLE, BUSY, RESP.
REQ-013 IDLE: when pmem_read or pmem_write is high at an edge, SHALL latch op, index = pmem_address[4+IDX_W-1:4] and pmem_wdata, load counter = LATENCY-1, and go to BUSY (to RESP directly if LATENCY=1).
REQ-014 With both pmem_read and pmem_write high in IDLE, SHALL accept as a write.
REQ-015 BUSY: SHALL decrement counter each cycle; at zero, SHALL go to RESP.
REQ-016 pmem_resp SHALL be high exactly during RESP, LATENCY cycles after the accepting edge; RESP always goes to IDLE next edge.
REQ-017 Read: the edge entering RESP SHALL load pmem_rdata from the latched index; pmem_rdata holds until the next read completes.
REQ-018 Write: the line SHALL be committed on the edge leaving RESP; a read accepted the following cycle returns the new data.
REQ-019 Inputs changing during BUSY SHALL be ignored except REQ-020.
REQ-020 If pmem_read and pmem_write are both low during BUSY, SHALL abort to IDLE, with no pmem_resp and no commit.
REQ-021 Address bits above the index SHALL be ignored; addresses alias modulo 2**IDX_W lines.
REQ-022 A request high in the cycle after RESP SHALL be accepted as a new transaction; back-to-back throughput is one line per LATENCY+1 cycles.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, counter 0, pmem_resp 0, pmem_rdata 0, proto_err 0, and every storage line 0.
REQ-024 Reset during BUSY or RESP SHALL discard the transaction with no commit.
REQ-025 The first request SHALL be accepted at the first rising edge with rst_n high.

Configuration
REQ-026 With PMEM_PROTOCOL_CHECK_EN defined, proto_err SHALL set on any of: read and write both high in IDLE; abort per REQ-020; pmem_address or op changed during BUSY.
REQ-027 Once set, proto_err SHALL stay high until reset.
REQ-028 Without PMEM_PROTOCOL_CHECK_EN, proto_err SHALL be constant 0 and checking logic absent.

Structure
REQ-029 lc3b_word, lc3b_line and new constant LC3B_LINE_OFFSET_BITS = 4 SHALL live in package lc3b_types.
REQ-030 The FSM state enum SHALL be local to the module.
REQ-031 Storage SHALL be sub-module line_mem_array: async-reset array, one write port with enable, combinational read at index.

Verification (LATENCY=4, IDX_W=4 unless stated)
REQ-032 Write 0x0040, data 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, then read 0x0048 -> pmem_resp 4 cycles after each accept; rdata equals the written line.
REQ-033 Write 0x1040, data all-ones, then read 0x0040 -> rdata all-ones (alias).
REQ-034 Read accepted, then pmem_read dropped after 2 cycles -> no pmem_resp; with PMEM_PROTOCOL_CHECK_EN, proto_err=1 and sticky.
REQ-035 rst_n low mid-write to 0x0020 -> outputs 0 immediately; a later read of 0x0020 returns 0.
REQ-036 LATENCY=1 back-to-back reads of 0x0000 and 0x0010 held continuously -> pmem_resp at cycles 1 and 3.
REQ-037 Read and write both high at 0x0030 -> treated as write; proto_err=1 only with the macro defined.

Source files
------------

// File: rtl/lc3b_types.sv
// LC-3b shared types: 16-bit word, 128-bit cache line, line offset width.
package lc3b_types;
    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;
    localparam int LC3B_LINE_OFFSET_BITS = 4;
endpackage

// File: rtl/line_mem_responder_if.sv
// Physical-memory line bus between a cache (master) and a line memory (slave).
interface line_mem_responder_if;
    import lc3b_types::*;

    logic     pmem_read;
    logic     pmem_write;
    lc3b_word pmem_address;
    lc3b_line pmem_wdata;
    logic     pmem_resp;
    lc3b_line pmem_rdata;
    logic     proto_err;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_resp, pmem_rdata, proto_err
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_resp, pmem_rdata, proto_err
    );
endinterface

// File: rtl/line_mem_array.sv
// Line storage: 2**IDX_W lines, cleared by reset, one synchronous write port,
// combinational read at ridx.
module line_mem_array
    import lc3b_types::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  lc3b_line         wdata,
    input  logic [IDX_W-1:0] ridx,
    output lc3b_line         rdata
);
    lc3b_line mem [2**IDX_W];

    // Clear every line on reset, otherwise write the addressed line when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**IDX_W; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];
endmodule

// File: rtl/line_mem_responder.sv
// Line memory responder with fixed latency for an LC-3b cache pmem port.
// Optional feature: define PMEM_PROTOCOL_CHECK_EN to build the sticky
// protocol-violation detector; otherwise proto_err is tied low.
module line_mem_responder
    import lc3b_types::*;
#(
    parameter int LATENCY = 4,
    parameter int IDX_W   = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    line_mem_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t           state;
    logic [3:0]       cnt;
    logic             op_write;
    logic [IDX_W-1:0] idx;
    lc3b_line         wdata_q;
    lc3b_line         rdata_q;
    logic             resp_q;
    logic             perr_q;

    logic [IDX_W-1:0] addr_idx;
    logic [IDX_W-1:0] ridx;
    logic             req;
    logic             mem_we;
    lc3b_line         mem_rdata;
    logic             unused_addr;

    assign addr_idx = bus.pmem_address[LC3B_LINE_OFFSET_BITS +: IDX_W];
    assign req      = bus.pmem_read | bus.pmem_write;
    // In IDLE the read port follows the live address so LATENCY=1 reads
    // can load rdata on the accepting edge; afterwards it uses the latched index.
    assign ridx     = (state == IDLE) ? addr_idx : idx;
    // The line is committed on the edge that leaves RESP.
    assign mem_we   = (state == RESP) && op_write;
    // Offset bits and bits above the index are deliberately ignored.
    assign unused_addr = ^bus.pmem_address;

    line_mem_array #(.IDX_W(IDX_W)) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .widx  (idx),
        .wdata (wdata_q),
        .ridx  (ridx),
        .rdata (mem_rdata)
    );

    // Transaction FSM: accept, count down the latency, pulse resp for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            op_write <= 1'b0;
            idx      <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            resp_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        // Write wins when both strobes are high.
                        op_write <= bus.pmem_write;
                        idx      <= addr_idx;
                        wdata_q  <= bus.pmem_wdata;
                        if (LATENCY == 1) begin
                            state  <= RESP;
                            cnt    <= '0;
                            resp_q <= 1'b1;
                            if (!bus.pmem_write) begin
                                rdata_q <= mem_rdata;
                            end
                        end else begin
                            state <= BUSY;
                            cnt   <= 4'(LATENCY - 1);
                        end
                    end
                end
                BUSY: begin
                    if (!req) begin
                        // Requester withdrew: drop the transaction silently.
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == 4'd1) begin
                        state  <= RESP;
                        cnt    <= '0;
                        resp_q <= 1'b1;
                        if (!op_write) begin
                            rdata_q <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    resp_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    resp_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef PMEM_PROTOCOL_CHECK_EN
    lc3b_word addr_q;

    // Sticky violation flag: dual strobe, abort, or address/op change while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            perr_q <= 1'b0;
        end else begin
            if (state == IDLE && req) begin
                addr_q <= bus.pmem_address;
            end
            if (state == IDLE && bus.pmem_read && bus.pmem_write) begin
                perr_q <= 1'b1;
            end
            if (state == BUSY) begin
                if (!req) begin
                    perr_q <= 1'b1;
                end else if (bus.pmem_address != addr_q || bus.pmem_write != op_write) begin
                    perr_q <= 1'b1;
                end
            end
        end
    end
`else
    assign perr_q = 1'b0;
`endif

    assign bus.pmem_resp  = resp_q;
    assign bus.pmem_rdata = rdata_q;
    assign bus.proto_err  = perr_q;
endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: LATENCY=4 instance plus a LATENCY=1 instance.
module tb_line_mem_responder;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    logic exp_perr = 1'b0;

`ifdef PMEM_PROTOCOL_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    localparam logic [127:0] D1   = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    localparam logic [127:0] ONES = {128{1'b1}};
    localparam logic [127:0] D2   = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    localparam logic [127:0] D3   = 128'h3333_3333_CAFE_F00D_3333_3333_1234_5678;
    localparam logic [127:0] D4   = 128'h7777_0000_7777_0000_A5A5_5A5A_0F0F_F0F0;
    localparam logic [127:0] D6   = 128'h6666_6666_6666_6666_0102_0304_0506_0708;

    line_mem_responder_if bus_a();
    line_mem_responder_if bus_b();

    line_mem_responder #(.LATENCY(4), .IDX_W(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    line_mem_responder #(.LATENCY(1), .IDX_W(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    task automatic drive_a(input logic rd, input logic wr, input logic [15:0] a, input logic [127:0] d);
        bus_a.pmem_read    = rd;
        bus_a.pmem_write   = wr;
        bus_a.pmem_address = a;
        bus_a.pmem_wdata   = d;
    endtask

    task automatic drive_b(input logic rd, input logic wr, input logic [15:0] a, input logic [127:0] d);
        bus_b.pmem_read    = rd;
        bus_b.pmem_write   = wr;
        bus_b.pmem_address = a;
        bus_b.pmem_wdata   = d;
    endtask

    // Called at a negedge; returns the cycle (1 = cycle after the accepting edge)
    // in which resp was seen, or -1. Ends at a negedge with the request still held.
    task automatic run_a(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [127:0] d, output int rc);
        drive_a(rd, wr, a, d);
        @(posedge clk);
        rc = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus_a.pmem_resp) begin
                rc = c;
                break;
            end
            @(posedge clk);
        end
        if (rc < 0) @(negedge clk);
    endtask

    task automatic idle_cycle_a();
        drive_a(1'b0, 1'b0, 16'h0000, '0);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_vec++; if (bus_a.pmem_resp !== 1'b0) begin n_err++; $display("FAIL rst_resp_a: got %0b expected 0", bus_a.pmem_resp); end
        n_vec++; if (bus_a.pmem_rdata !== '0) begin n_err++; $display("FAIL rst_rdata_a: got %0h expected 0", bus_a.pmem_rdata); end
        n_vec++; if (bus_a.proto_err !== 1'b0) begin n_err++; $display("FAIL rst_perr_a: got %0b expected 0", bus_a.proto_err); end
        n_vec++; if (bus_b.pmem_resp !== 1'b0) begin n_err++; $display("FAIL rst_resp_b: got %0b expected 0", bus_b.pmem_resp); end
        n_vec++; if (bus_b.pmem_rdata !== '0) begin n_err++; $display("FAIL rst_rdata_b: got %0h expected 0", bus_b.pmem_rdata); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        int rc;
        run_a(1'b0, 1'b1, 16'h0040, D1, rc);
        n_vec++; if (rc !== 4) begin n_err++; $display("FAIL wr_latency: got %0d expected 4", rc); end
        idle_cycle_a();
        n_vec++; if (bus_a.pmem_resp !== 1'b0) begin n_err++; $display("FAIL resp_single_pulse: got %0b expected 0", bus_a.pmem_resp); end
        run_a(1'b1, 1'b0, 16'h0048, '0, rc);
        n_vec++; if (rc !== 4) begin n_err++; $display("FAIL rd_latency: got %0d expected 4", rc); end
        n_vec++; if (bus_a.pmem_rdata !== D1) begin n_err++; $display("FAIL rd_data: got %0h expected %0h", bus_a.pmem_rdata, D1); end
        n_vec++; if (bus_a.proto_err !== exp_perr) begin n_err++; $display("FAIL wr_rd_perr: got %0b expected %0b", bus_a.proto_err, exp_perr); end
        idle_cycle_a();
    endtask

    task automatic test_alias();
        int rc;
        run_a(1'b0, 1'b1, 16'h1040, ONES, rc);
        n_vec++; if (rc !== 4) begin n_err++; $display("FAIL alias_wr_latency: got %0d expected 4", rc); end
        idle_cycle_a();
        run_a(1'b1, 1'b0, 16'h0040, '0, rc);
        n_vec++; if (bus_a.pmem_rdata !== ONES) begin n_err++; $display("FAIL alias_rdata: got %0h expected %0h", bus_a.pmem_rdata, ONES); end
        idle_cycle_a();
    endtask

    task automatic test_back_to_back();
        int rc;
        int hit;
        run_a(1'b0, 1'b1, 16'h0070, D4, rc);
        n_vec++; if (rc !== 4) begin n_err++; $display("FAIL b2b_wr_latency: got %0d expected 4", rc); end
        drive_a(1'b1, 1'b0, 16'h0070, '0);
        hit = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus_a.pmem_resp) begin
                hit = c;
                break;
            end
        end
        n_vec++; if (hit !== 5) begin n_err++; $display("FAIL b2b_period: got %0d expected 5", hit); end
        n_vec++; if (bus_a.pmem_rdata !== D4) begin n_err++; $display("FAIL b2b_rdata: got %0h expected %0h", bus_a.pmem_rdata, D4); end
        idle_cycle_a();
    endtask

    task automatic test_both_high();
        int rc;
        exp_perr = CHK;
        run_a(1'b1, 1'b1, 16'h0030, D3, rc);
        n_vec++; if (rc !== 4) begin n_err++; $display("FAIL both_latency: got %0d expected 4", rc); end
        n_vec++; if (bus_a.pmem_rdata !== D4) begin n_err++; $display("FAIL both_rdata_held: got %0h expected %0h", bus_a.pmem_rdata, D4); end
        n_vec++; if (bus_a.proto_err !== exp_perr) begin n_err++; $display("FAIL both_perr: got %0b expected %0b", bus_a.proto_err, exp_perr); end
        idle_cycle_a();
        run_a(1'b1, 1'b0, 16'h0030, '0, rc);
        n_vec++; if (bus_a.pmem_rdata !== D3) begin n_err++; $display("FAIL both_written: got %0h expected %0h", bus_a.pmem_rdata, D3); end
        idle_cycle_a();
    endtask

    task automatic test_ignore_busy_changes();
        int hit;
        drive_a(1'b1, 1'b0, 16'h0030, '0);
        @(posedge clk);
        #1;
        bus_a.pmem_address = 16'h0070;
        bus_a.pmem_wdata   = D1;
        exp_perr = CHK;
        hit = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus_a.pmem_resp) begin
                hit = c;
                break;
            end
            @(posedge clk);
        end
        n_vec++; if (hit !== 4) begin n_err++; $display("FAIL ignore_latency: got %0d expected 4", hit); end
        n_vec++; if (bus_a.pmem_rdata !== D3) begin n_err++; $display("FAIL ignore_rdata: got %0h expected %0h", bus_a.pmem_rdata, D3); end
        n_vec++; if (bus_a.proto_err !== exp_perr) begin n_err++; $display("FAIL ignore_perr: got %0b expected %0b", bus_a.proto_err, exp_perr); end
        idle_cycle_a();
    endtask

    task automatic test_abort();
        int rc;
        int nresp;
        drive_a(1'b1, 1'b0, 16'h0040, '0);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        drive_a(1'b0, 1'b0, 16'h0000, '0);
        exp_perr = CHK;
        nresp = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus_a.pmem_resp) nresp++;
        end
        n_vec++; if (nresp !== 0) begin n_err++; $display("FAIL abort_rd_resp: got %0d pulses expected 0", nresp); end
        n_vec++; if (bus_a.pmem_rdata !== D3) begin n_err++; $display("FAIL abort_rdata_held: got %0h expected %0h", bus_a.pmem_rdata, D3); end
        n_vec++; if (bus_a.proto_err !== exp_perr) begin n_err++; $display("FAIL abort_perr: got %0b expected %0b", bus_a.proto_err, exp_perr); end
        repeat (3) @(negedge clk);
        n_vec++; if (bus_a.proto_err !== exp_perr) begin n_err++; $display("FAIL abort_perr_sticky: got %0b expected %0b", bus_a.proto_err, exp_perr); end
        drive_a(1'b0, 1'b1, 16'h0060, D2);
        @(posedge clk);
        @(negedge clk);
        drive_a(1'b0, 1'b0, 16'h0000, '0);
        nresp = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus_a.pmem_resp) nresp++;
        end
        n_vec++; if (nresp !== 0) begin n_err++; $display("FAIL abort_wr_resp: got %0d pulses expected 0", nresp); end
        run_a(1'b1, 1'b0, 16'h0060, '0, rc);
        n_vec++; if (rc !== 4) begin n_err++; $display("FAIL post_abort_latency: got %0d expected 4", rc); end
        n_vec++; if (bus_a.pmem_rdata !== '0) begin n_err++; $display("FAIL abort_no_commit: got %0h expected 0", bus_a.pmem_rdata); end
        idle_cycle_a();
    endtask

    task automatic test_reset_mid_write();
        int rc;
        run_a(1'b1, 1'b0, 16'h0040, '0, rc);
        n_vec++; if (bus_a.pmem_rdata !== ONES) begin n_err++; $display("FAIL pre_reset_rdata: got %0h expected %0h", bus_a.pmem_rdata, ONES); end
        idle_cycle_a();
        drive_a(1'b0, 1'b1, 16'h0020, D2);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        exp_perr = 1'b0;
        #1;
        n_vec++; if (bus_a.pmem_resp !== 1'b0) begin n_err++; $display("FAIL midrst_resp: got %0b expected 0", bus_a.pmem_resp); end
        n_vec++; if (bus_a.pmem_rdata !== '0) begin n_err++; $display("FAIL midrst_rdata: got %0h expected 0", bus_a.pmem_rdata); end
        n_vec++; if (bus_a.proto_err !== 1'b0) begin n_err++; $display("FAIL midrst_perr: got %0b expected 0", bus_a.proto_err); end
        drive_a(1'b0, 1'b0, 16'h0000, '0);
        @(negedge clk);
        rst_n = 1'b1;
        run_a(1'b1, 1'b0, 16'h0020, '0, rc);
        n_vec++; if (rc !== 4) begin n_err++; $display("FAIL midrst_rd_latency: got %0d expected 4", rc); end
        n_vec++; if (bus_a.pmem_rdata !== '0) begin n_err++; $display("FAIL midrst_no_commit: got %0h expected 0", bus_a.pmem_rdata); end
        idle_cycle_a();
        drive_a(1'b0, 1'b1, 16'h0010, D1);
        run_a(1'b1, 1'b0, 16'h0040, '0, rc);
        n_vec++; if (bus_a.pmem_rdata !== '0) begin n_err++; $display("FAIL midrst_storage_cleared: got %0h expected 0", bus_a.pmem_rdata); end
        idle_cycle_a();
    endtask

    task automatic test_latency1();
        logic [6:0] mask;
        drive_b(1'b0, 1'b1, 16'h0000, D6);
        @(posedge clk);
        @(negedge clk);
        n_vec++; if (bus_b.pmem_resp !== 1'b1) begin n_err++; $display("FAIL l1_wr_resp: got %0b expected 1", bus_b.pmem_resp); end
        drive_b(1'b0, 1'b0, 16'h0000, '0);
        @(posedge clk);
        @(negedge clk);
        drive_b(1'b1, 1'b0, 16'h0000, '0);
        @(posedge clk);
        mask = '0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            mask[c] = bus_b.pmem_resp;
            if (c == 1) begin
                n_vec++; if (bus_b.pmem_rdata !== D6) begin n_err++; $display("FAIL l1_rdata0: got %0h expected %0h", bus_b.pmem_rdata, D6); end
                bus_b.pmem_address = 16'h0010;
            end
            if (c == 3) begin
                n_vec++; if (bus_b.pmem_rdata !== '0) begin n_err++; $display("FAIL l1_rdata1: got %0h expected 0", bus_b.pmem_rdata); end
                drive_b(1'b0, 1'b0, 16'h0000, '0);
            end
            @(posedge clk);
        end
        @(negedge clk);
        n_vec++; if (mask !== 7'b0001010) begin n_err++; $display("FAIL l1_resp_cycles: got %b expected 0001010", mask); end
    endtask

    initial begin
        drive_a(1'b0, 1'b0, 16'h0000, '0);
        drive_b(1'b0, 1'b0, 16'h0000, '0);
        test_reset();
        test_write_read();
        test_alias();
        test_back_to_back();
        test_both_high();
        test_ignore_busy_changes();
        test_abort();
        test_reset_mid_write();
        test_latency1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
